// File: rtl/psddivide_arb.sv
// Round-robin front end for one shared psddivide sequential divider.
// Two valid/ready requesters in, one response channel with backpressure out.
module psddivide_arb #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_dividend0,
  input  logic [31:0] req_divisor0,
  input  logic [31:0] req_dividend1,
  input  logic [31:0] req_divisor1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_quotient,
  output logic [31:0] rsp_rest,
  output logic        rsp_divzero,
  output logic        busy,
  output logic        div_start,
  output logic        div_stop,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_rest
);

  typedef enum logic [2:0] {IDLE, START, RUN, STOP, CAPT, RESP} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_CYCLES - 1);

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic              ptr;
  logic              grant;
  logic              accept;
  logic [31:0]       sel_dividend;
  logic [31:0]       sel_divisor;

  // A lone requester always wins; on contention the pointer decides.
  always_comb begin
    grant = ptr;
    if (req_valid == 2'b01)
      grant = 1'b0;
    else if (req_valid == 2'b10)
      grant = 1'b1;
    req_ready = 2'b00;
    if (reset && state == IDLE && req_valid[grant])
      req_ready[grant] = 1'b1;
    accept       = |(req_valid & req_ready);
    sel_dividend = grant ? req_dividend1 : req_dividend0;
    sel_divisor  = grant ? req_divisor1  : req_divisor0;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (accept) next_state = (sel_divisor == 32'd0) ? RESP : START;
      START: next_state = RUN;
      RUN:   if (cnt == LAST) next_state = STOP;
      STOP:  next_state = CAPT;
      CAPT:  next_state = RESP;
      RESP:  if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      ptr          <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      rsp_id       <= 1'b0;
      rsp_quotient <= '0;
      rsp_rest     <= '0;
      rsp_divzero  <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (accept) begin
            div_dividend <= sel_dividend;
            div_divisor  <= sel_divisor;
            rsp_id       <= grant;
            ptr          <= ~grant;
            // Divide-by-zero is answered here and never reaches the divider.
            if (sel_divisor == 32'd0) begin
              rsp_quotient <= 32'hFFFF_FFFF;
              rsp_rest     <= sel_dividend;
              rsp_divzero  <= 1'b1;
            end
          end
        end
        START: cnt <= '0;
        RUN:   cnt <= cnt + CNT_W'(1);
        CAPT: begin
          rsp_quotient <= div_quotient;
          rsp_rest     <= div_rest;
          rsp_divzero  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign div_start = (state == START);
  assign div_stop  = (state == STOP);
  assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_psddivide_arb.sv
// Scoreboard bench for psddivide_arb: a latency/round-robin reference model
// predicts every cycle's handshake outputs and every response payload.
module tb_psddivide_arb;

  localparam int DIV_CYCLES = 32;
  localparam int LAT        = DIV_CYCLES + 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rv0 = 1'b0, rv1 = 1'b0;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_dividend0 = '0, req_divisor0 = '0;
  logic [31:0] req_dividend1 = '0, req_divisor1 = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_divzero, busy;
  logic [31:0] rsp_quotient, rsp_rest;
  logic        div_start, div_stop;
  logic [31:0] div_dividend, div_divisor;
  logic [31:0] div_quotient = '0, div_rest = '0;

  assign req_valid = {rv1, rv0};

  always #5 clock = ~clock;

  psddivide_arb #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(6)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend0(req_dividend0), .req_divisor0(req_divisor0),
    .req_dividend1(req_dividend1), .req_divisor1(req_divisor1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_rest(rsp_rest), .rsp_divzero(rsp_divzero),
    .busy(busy), .div_start(div_start), .div_stop(div_stop),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_rest(div_rest)
  );

  // Divider stand-in: operands taken at start, results appear at stop.
  logic [31:0] la = '0, lb = '0;
  always @(posedge clock) begin
    if (div_start) begin
      la           <= div_dividend;
      lb           <= div_divisor;
      div_quotient <= 32'hDEAD_BEEF;
      div_rest     <= 32'hBAD0_BAD0;
    end else if (div_stop) begin
      div_quotient <= (lb == 0) ? 32'hFFFF_FFFF : la / lb;
      div_rest     <= (lb == 0) ? la : la % lb;
    end
  end

  typedef struct packed {
    logic        id;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } rsp_t;

  rsp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   rspMode = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic pickGrant(input logic [1:0] v, input logic p);
    if (v == 2'b01) return 1'b0;
    if (v == 2'b10) return 1'b1;
    return p;
  endfunction

  // Reference model: idle / counting down to the response / holding the response.
  logic        m_idle = 1'b1, m_resp = 1'b0, m_ptr = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_a = '0, m_b = '0;

  always @(posedge clock or negedge reset) begin
    logic        g;
    logic [31:0] a, b;
    rsp_t        e;
    if (!reset) begin
      m_idle = 1'b1; m_resp = 1'b0; m_ptr = 1'b0; m_cnt = 0;
      m_a = '0; m_b = '0;
      sbq.delete();
    end else if (m_idle) begin
      if (req_valid != 2'b00) begin
        g = pickGrant(req_valid, m_ptr);
        a = g ? req_dividend1 : req_dividend0;
        b = g ? req_divisor1  : req_divisor0;
        m_ptr = ~g; m_a = a; m_b = b; m_idle = 1'b0;
        e.id = g;
        if (b == 0) begin
          e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1;
          m_cnt = 0; m_resp = 1'b1;
        end else begin
          e.q = a / b; e.r = a % b; e.dz = 1'b0;
          m_cnt = LAT;
        end
        sbq.push_back(e);
      end
    end else if (!m_resp) begin
      m_cnt--;
      if (m_cnt == 0) m_resp = 1'b1;
    end else if (rsp_ready) begin
      m_resp = 1'b0; m_idle = 1'b1;
    end
  end

  function automatic logic [1:0] expReady();
    if (!reset || !m_idle || req_valid == 2'b00) return 2'b00;
    return pickGrant(req_valid, m_ptr) ? 2'b10 : 2'b01;
  endfunction

  // Monitor: handshake timing every cycle, payload against the scoreboard head.
  always @(negedge clock) begin
    checkOutput("req_ready", req_ready, expReady());
    checkOutput("busy", busy, !m_idle);
    checkOutput("rsp_valid", rsp_valid, m_resp);
    checkOutput("div_start", div_start, !m_idle && !m_resp && m_cnt == LAT);
    checkOutput("div_stop", div_stop, !m_idle && !m_resp && m_cnt == 2);
    if (!m_idle && !m_resp) begin
      checkOutput("div_dividend", div_dividend, m_a);
      checkOutput("div_divisor", div_divisor, m_b);
    end
    if (rsp_valid) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL rsp_unexpected: got response id %0d expected none at %0t", rsp_id, $time);
      end else begin
        checkOutput("rsp_id", rsp_id, sbq[0].id);
        checkOutput("rsp_quotient", rsp_quotient, sbq[0].q);
        checkOutput("rsp_rest", rsp_rest, sbq[0].r);
        checkOutput("rsp_divzero", rsp_divzero, sbq[0].dz);
        if (rsp_ready) void'(sbq.pop_front());
      end
    end
  end

  always begin
    @(posedge clock);
    #1;
    case (rspMode)
      0: rsp_ready = 1'b1;
      2: rsp_ready = ($urandom_range(0, 3) != 0);
      default: ;
    endcase
  end

  task automatic applyStimulus(input int id, input logic [31:0] a, input logic [31:0] b);
    bit ok = 0;
    @(posedge clock);
    #1;
    if (id == 0) begin rv0 = 1'b1; req_dividend0 = a; req_divisor0 = b; end
    else         begin rv1 = 1'b1; req_dividend1 = a; req_divisor1 = b; end
    for (int k = 0; k < 500; k++) begin
      @(negedge clock);
      if (req_valid[id] && req_ready[id]) begin ok = 1; break; end
    end
    @(posedge clock);
    #1;
    if (id == 0) rv0 = 1'b0; else rv1 = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL accept_timeout: requester %0d got no accept, required within 500 cycles", id);
    end
  endtask

  task automatic waitIdle(input int maxCycles);
    bit ok = 0;
    for (int k = 0; k < maxCycles; k++) begin
      @(negedge clock);
      if (m_idle && sbq.size() == 0) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL drain_timeout: %0d responses outstanding, required 0", sbq.size());
    end
  endtask

  task automatic randomRequester(input int id, input int n);
    logic [31:0] a, b;
    for (int k = 0; k < n; k++) begin
      a = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      else if ($urandom_range(0, 1) == 1) b = $urandom;
      else b = $urandom_range(1, 255);
      applyStimulus(id, a, b);
      repeat ($urandom_range(0, 40)) @(posedge clock);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_req_ready"}, req_ready, 2'b00);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    checkOutput({tag, "_div_start"}, div_start, 1'b0);
    checkOutput({tag, "_div_stop"}, div_stop, 1'b0);
    checkOutput({tag, "_div_dividend"}, div_dividend, 32'd0);
    checkOutput({tag, "_div_divisor"}, div_divisor, 32'd0);
    checkOutput({tag, "_rsp_id"}, rsp_id, 1'b0);
    checkOutput({tag, "_rsp_quotient"}, rsp_quotient, 32'd0);
    checkOutput({tag, "_rsp_rest"}, rsp_rest, 32'd0);
    checkOutput({tag, "_rsp_divzero"}, rsp_divzero, 1'b0);
  endtask

  initial begin
    bit seen;
    // Reset held with both requesters asking: nothing may be granted.
    rv0 = 1'b1; rv1 = 1'b1;
    req_dividend0 = 32'h1111_2222; req_divisor0 = 32'h3;
    req_dividend1 = 32'h3333_4444; req_divisor1 = 32'h5;
    #23;
    checkAllZero("reset");
    rv0 = 1'b0; rv1 = 1'b0;
    @(posedge clock); #1; reset = 1'b1;

    // Both requesters contend from the first cycle: grants must alternate 0,1,0,1.
    fork
      begin
        applyStimulus(0, 32'h1234_5678, 32'h0BEE_FEBA);
        applyStimulus(0, 32'h0000_0001, 32'h0000_0000);
      end
      begin
        applyStimulus(1, 32'hFFFF_FFFF, 32'h0000_0001);
        applyStimulus(1, 32'h1111_1111, 32'hFFFF_FFFF);
      end
    join
    waitIdle(300);

    // Backpressure: response held 5 cycles while requester 1 waits.
    rspMode = 3;
    rsp_ready = 1'b0;
    fork
      applyStimulus(0, 32'hCAFE_F00D, 32'h0000_1234);
      begin
        repeat (3) @(posedge clock);
        applyStimulus(1, 32'h0000_0064, 32'h0000_0007);
      end
      begin
        seen = 0;
        for (int k = 0; k < 200; k++) begin
          @(negedge clock);
          if (rsp_valid) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin
          errors++;
          $display("[TB] FAIL rsp_timeout: rsp_valid stayed 0, required high within 200 cycles");
        end
        repeat (5) @(negedge clock);
        @(posedge clock); #1; rsp_ready = 1'b1;
      end
    join
    waitIdle(300);
    rspMode = 0;

    // Reset in the middle of RUN, then the pointer must prefer requester 0 again.
    applyStimulus(0, 32'h0BAD_CAFE, 32'h0000_0013);
    repeat (11) @(posedge clock);
    #1; reset = 1'b0;
    #1; checkAllZero("midrun_reset");
    @(posedge clock); #1; reset = 1'b1;
    fork
      applyStimulus(0, 32'hEDCA_1234, 32'h0BEE_FEBA);
      applyStimulus(1, 32'h8000_0000, 32'h0000_0003);
    join
    waitIdle(300);

    // Randomized contention with random response backpressure.
    rspMode = 2;
    fork
      randomRequester(0, 15);
      randomRequester(1, 15);
    join
    waitIdle(500);
    rspMode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
